// File: rtl/socket_range_regs_if.sv
// Avalon-MM slave bus bundle for the range register block.
// No logic inside; the slave drives readdata/waitrequest, the master the rest.
// Backpressure: the master holds its request while waitrequest is high.
interface socket_range_regs_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic              read;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/socket_range_regs.sv
// NUM_CH range registers behind an Avalon-MM slave, with readback and a latched/maskable W1C irq.
// Latency: a request presented in cycle 0 is acknowledged in cycle WAIT_CYCLES+1; irq lags status by 1 cycle.
// Backpressure: waitrequest is high in every state except ACK. Option macro: SOCKET_RANGE_ZERO_HOLD_EN.
module socket_range_regs #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 8,
  parameter int RESET_VAL   = 128,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  socket_range_regs_if.slave     mm,
  input  logic [NUM_CH-1:0]      irq_src,
  output logic                   irq,
  output logic [NUM_CH*CH_W-1:0] range_out,
  output logic [NUM_CH-1:0]      update_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(NUM_CH + 2);
  localparam logic [31:0]       ID_VAL    = {16'h5250, 8'(NUM_CH), 8'(CH_W)};
  localparam logic [CH_W-1:0]   RST_RANGE = CH_W'(RESET_VAL);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [CH_W-1:0]     range_q [NUM_CH];
  logic [NUM_CH-1:0]   status_q, status_d;
  logic [NUM_CH-1:0]   enable_q;
  logic [NUM_CH-1:0]   src_q;
  logic [NUM_CH-1:0]   pulse_q;
  logic                irq_q;

  logic                req;
  logic                commit;
  logic [31:0]         rd_mux;
  logic [NUM_CH-1:0]   wr_ch;
  logic [NUM_CH-1:0]   clr;
  logic [CH_W-1:0]     wr_data;
  logic                unused_wdata;

  assign req          = mm.read | mm.write;
  assign commit       = (state_q == S_ACK) && mm.write;
  assign wr_data      = mm.writedata[CH_W-1:0];
  assign unused_wdata = ^mm.writedata;

  assign mm.waitrequest = (state_q != S_ACK);
  assign mm.readdata    = readdata_q;
  assign irq            = irq_q;
  assign update_pulse   = pulse_q;

  // Handshake FSM: IDLE loads the wait counter, WAIT counts down to ACK or aborts on a dropped request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read decode; unmapped words read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mm.address == ADDR_W'(i)) rd_mux = 32'(range_q[i]);
    end
    if (mm.address == A_STATUS) rd_mux = 32'(status_q);
    if (mm.address == A_ENABLE) rd_mux = 32'(enable_q);
    if (mm.address == A_ID)     rd_mux = ID_VAL;
  end

  // readdata is captured on entry to ACK; a combined read+write is a write and returns zero.
  always_comb begin
    readdata_d = '0;
    if (state_d == S_ACK && mm.read && !mm.write) readdata_d = rd_mux;
  end

  // Per-channel commit strobes; these also become update_pulse one cycle later.
  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef SOCKET_RANGE_ZERO_HOLD_EN
      wr_ch[i] = commit && (mm.address == ADDR_W'(i)) && (wr_data != '0);
`else
      wr_ch[i] = commit && (mm.address == ADDR_W'(i));
`endif
    end
  end

  // Status: rising edges set, W1C clears, a set in the same cycle as a clear wins.
  always_comb begin
    clr = '0;
    if (commit && mm.address == A_STATUS) clr = mm.writedata[NUM_CH-1:0];
    status_d = (status_q & ~clr) | (irq_src & ~src_q);
  end

  // Flattened view of the range registers for the fabric side.
  always_comb begin
    range_out = '0;
    for (int i = 0; i < NUM_CH; i++) range_out[i*CH_W +: CH_W] = range_q[i];
  end

  // All state; reset aborts any transfer in flight without committing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      status_q   <= '0;
      enable_q   <= '0;
      src_q      <= '0;
      pulse_q    <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) range_q[i] <= RST_RANGE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      status_q   <= status_d;
      src_q      <= irq_src;
      pulse_q    <= wr_ch;
      irq_q      <= |(status_q & enable_q);
      if (commit && mm.address == A_ENABLE) enable_q <= mm.writedata[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ch[i]) range_q[i] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_socket_range_regs.sv
// Bench for socket_range_regs: default instance (WAIT_CYCLES=1) plus a WAIT_CYCLES=3 instance.
// Expected readdata and update_pulse values are queued when stimulus is driven and
// popped by monitors when the DUT acknowledges a read or raises a pulse.
module tb_socket_range_regs;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic [3:0]  irq_src, irq_src3;
  logic        irq, irq3;
  logic [31:0] range_out, range_out3;
  logic [3:0]  upd, upd3;

  int          checks = 0;
  int          failures = 0;
  int          pulse3_cnt = 0;
  exp_t        rd_q[$];
  logic [3:0]  pulse_q[$];
  logic [7:0]  m_range[4];

  always #5 clk = ~clk;

  socket_range_regs_if #(.ADDR_W(5)) bus();
  socket_range_regs_if #(.ADDR_W(5)) bus3();

  socket_range_regs #(.NUM_CH(4), .CH_W(8), .RESET_VAL(128), .WAIT_CYCLES(1), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .mm(bus), .irq_src(irq_src), .irq(irq),
    .range_out(range_out), .update_pulse(upd)
  );

  socket_range_regs #(.NUM_CH(4), .CH_W(8), .RESET_VAL(128), .WAIT_CYCLES(3), .ADDR_W(5)) dut3 (
    .clk(clk), .reset(reset3), .mm(bus3), .irq_src(irq_src3), .irq(irq3),
    .range_out(range_out3), .update_pulse(upd3)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_range();
    return {m_range[3], m_range[2], m_range[1], m_range[0]};
  endfunction

  // Read scoreboard and pulse scoreboard for the main instance; pulse counter for dut3.
  always @(negedge clk) begin
    if (!reset && bus.read && !bus.waitrequest) begin
      if (rd_q.size() == 0) check_val("rd_unexpected", bus.readdata, 32'hDEAD_BEEF);
      else begin
        exp_t e;
        e = rd_q.pop_front();
        check_val(e.tag, bus.readdata, e.val);
      end
    end
    if (upd != 4'd0) begin
      if (pulse_q.size() == 0) check_val("pulse_extra", upd, 4'd0);
      else check_val("pulse", upd, pulse_q.pop_front());
    end
    if (upd3 != 4'd0) pulse3_cnt++;
  end

  // Counts cycles with waitrequest high, starting in the cycle the request is presented.
  task automatic wait_ack(output int lat);
    lat = 0;
    @(negedge clk);
    while (bus.waitrequest && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    int lat;
    @(posedge clk); #1;
    bus.address = a;
    bus.read    = 1'b1;
    rd_q.push_back('{tag, exp});
    wait_ack(lat);
    check_val({tag, "_lat"}, lat, 2);
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] pm, input string tag);
    int lat;
    @(posedge clk); #1;
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    if (pm != 4'd0) pulse_q.push_back(pm);
    wait_ack(lat);
    check_val({tag, "_lat"}, lat, 2);
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; reset3 = 1'b1;
    irq_src = '0; irq_src3 = '0;
    bus.address = '0;  bus.write = 1'b0;  bus.read = 1'b0;  bus.writedata = '0;
    bus3.address = '0; bus3.write = 1'b0; bus3.read = 1'b0; bus3.writedata = '0;
    for (int i = 0; i < 4; i++) m_range[i] = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_waitreq", bus.waitrequest, 1);
    check_val("rst_irq", irq, 0);
    check_val("rst_pulse", upd, 0);
    check_val("rst_readdata", bus.readdata, 0);
    check_val("rst_range", range_out, 32'h8080_8080);
    reset = 1'b0; reset3 = 1'b0;

    // Defaults, ID and an unmapped word
    for (int i = 0; i < 4; i++) bus_read(5'(i), 32'h0000_0080, "range_dflt");
    bus_read(5'd6, 32'h5250_0408, "id");
    bus_read(5'd7, 32'h0, "unmapped");

    // Channel write: only channel 2 changes, one pulse on bit 2
    bus_write(5'd2, 32'h1234_56C3, 4'b0100, "wr_ch2");
    m_range[2] = 8'hC3;
    check_val("range_ch2", range_out[23:16], 8'hC3);
    check_val("range_all_a", range_out, model_range());

    // Zero write to channel 1
`ifdef SOCKET_RANGE_ZERO_HOLD_EN
    bus_write(5'd1, 32'h0, 4'b0000, "wr_zero");
`else
    bus_write(5'd1, 32'h0, 4'b0010, "wr_zero");
    m_range[1] = 8'h00;
`endif
    check_val("range_all_b", range_out, model_range());
    bus_read(5'd1, {24'h0, m_range[1]}, "range1_rb");

    // Unmapped write does nothing
    bus_write(5'd7, 32'hFFFF_FFFF, 4'b0000, "wr_unmapped");
    check_val("range_all_c", range_out, model_range());

    // Read and write together: write wins, readdata zero
    @(posedge clk); #1;
    bus.address = 5'd3; bus.writedata = 32'h11; bus.write = 1'b1; bus.read = 1'b1;
    rd_q.push_back('{"rw_both", 32'h0});
    pulse_q.push_back(4'b1000);
    wait_ack(lat);
    check_val("rw_both_lat", lat, 2);
    @(posedge clk); #1;
    bus.write = 1'b0; bus.read = 1'b0;
    m_range[3] = 8'h11;
    check_val("range_all_d", range_out, model_range());

    // Interrupts: enable 0x5, events on channels 0 and 1
    bus_write(5'd5, 32'h5, 4'b0000, "wr_en");
    bus_read(5'd5, 32'h5, "irq_en");
    @(posedge clk); #1; irq_src = 4'b0011;
    @(posedge clk); #1; irq_src = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_val("irq_set", irq, 1);
    bus_read(5'd4, 32'h3, "irq_status");
    bus_write(5'd4, 32'h1, 4'b0000, "w1c_0");
    repeat (2) @(posedge clk);
    #1;
    check_val("irq_clr", irq, 0);
    bus_read(5'd4, 32'h2, "status_w1c");

    // Held source does not re-set after clear
    @(posedge clk); #1; irq_src = 4'b0100;
    repeat (2) @(posedge clk);
    bus_read(5'd4, 32'h6, "status_held_set");
    bus_write(5'd4, 32'h4, 4'b0000, "w1c_2");
    bus_read(5'd4, 32'h2, "status_held_clr");
    irq_src = 4'b0000;

    // W1C of bit 0 in the same cycle as its rising edge: set wins
    @(posedge clk); #1;
    bus.address = 5'd4; bus.writedata = 32'h1; bus.write = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    irq_src = 4'b0001;
    @(negedge clk);
    check_val("setwins_ack", bus.waitrequest, 0);
    @(posedge clk); #1;
    bus.write = 1'b0; irq_src = 4'b0000;
    bus_read(5'd4, 32'h3, "status_setwins");
    check_val("irq_setwins", irq, 1);

    // Reset during WAIT on the WAIT_CYCLES=3 instance
    @(posedge clk); #1;
    bus3.address = 5'd0; bus3.writedata = 32'h55; bus3.write = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset3 = 1'b1;
    @(posedge clk); #1;
    reset3 = 1'b0;
    check_val("abort_range", range_out3[7:0], 8'h80);
    check_val("abort_pulse", pulse3_cnt, 0);
    lat = 0;
    @(negedge clk);
    while (bus3.waitrequest && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check_val("restart_lat", lat, 4);
    @(posedge clk); #1;
    bus3.write = 1'b0;
    check_val("restart_range", range_out3[7:0], 8'h55);
    repeat (2) @(posedge clk);
    #1;
    check_val("restart_pulses", pulse3_cnt, 1);
    check_val("dut3_irq", irq3, 0);
    check_val("dut3_readdata", bus3.readdata, 0);

    repeat (3) @(posedge clk);
    check_val("rd_q_empty", rd_q.size(), 0);
    check_val("pulse_q_empty", pulse_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/socket_range_regs.md
Name: socket_range_regs

Overview:
Parametrised Avalon-MM slave that holds NUM_CH range registers, each CH_W bits wide, written by the HPS over the lightweight bridge. Each range register drives the fabric-side actuator logic directly. The block adds per-channel addressing, readback, a latched/maskable interrupt with write-1-to-clear, and a deterministic waitrequest handshake with a programmable number of wait states.

Parameters:
NUM_CH, 4, number of range channels (1..16)
CH_W, 8, width of each range register (1..32)
RESET_VAL, 128, reset value of every range register (truncated to CH_W)
WAIT_CYCLES, 1, extra wait states per transfer (0..15)
ADDR_W, 5, word-address width; must satisfy 2^ADDR_W >= NUM_CH+3

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
address  in  ADDR_W  Avalon word address
write  in  1  Avalon write request
writedata  in  32  Avalon write data
read  in  1  Avalon read request
readdata  out  32  Avalon read data; valid when read && !waitrequest
waitrequest  out  1  Avalon stall
irq_src  in  NUM_CH  per-channel event inputs, synchronous to clk
irq  out  1  level interrupt to HPS
range_out  out  NUM_CH*CH_W  flattened range registers; channel i at [i*CH_W +: CH_W]
update_pulse  out  NUM_CH  one-cycle pulse when channel i is committed

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Register map (word address):
  - 0..NUM_CH-1: RANGE[i], R/W, data in bits [CH_W-1:0], upper bits read 0.
  - NUM_CH: IRQ_STATUS, W1C, bits [NUM_CH-1:0].
  - NUM_CH+1: IRQ_ENABLE, R/W, bits [NUM_CH-1:0].
  - NUM_CH+2: ID, RO = {16'h5250, NUM_CH[7:0], CH_W[7:0]}.
  - Other addresses: writes ignored, reads return 0.
- Handshake FSM, states IDLE, WAIT, ACK:
  - waitrequest = (state != ACK). Combinational from state only; high while idle.
  - IDLE: if read or write, load counter with WAIT_CYCLES. Go to ACK if WAIT_CYCLES==0, else go to WAIT.
  - WAIT: decrement counter; go to ACK when it reaches 1. If read and write both drop, return to IDLE with no commit.
  - ACK: commit the write, or present the registered readdata; go to IDLE next cycle.
  - Net effect: a request at cycle 0 completes at cycle WAIT_CYCLES+1. One transfer per WAIT_CYCLES+2 cycles.
- readdata is registered on entry to ACK and is 0 outside ACK.
- read and write asserted together: handled as a write; readdata = 0.
- RANGE commit in ACK sets RANGE[i] <= writedata[CH_W-1:0] and pulses update_pulse[i] for exactly 1 cycle, aligned to the cycle after ACK.
- IRQ:
  - status[i] sets on a rising edge of irq_src[i]. Edge detector register resets to 0.
  - W1C clears bits where writedata=1.
  - Set and clear in the same cycle: set wins.
  - irq = |(IRQ_STATUS & IRQ_ENABLE), registered, so 1-cycle latency from the status change.
  - irq_src held high does not re-set status after a clear.
- Reset values: RANGE[*]=RESET_VAL, IRQ_STATUS=0, IRQ_ENABLE=0, irq=0, readdata=0, update_pulse=0, state=IDLE (waitrequest=1).
- Reset during WAIT or ACK aborts the transfer with no commit. A request still asserted after reset restarts from IDLE.

Optional Feature:
- Macro: SOCKET_RANGE_ZERO_HOLD_EN.
- Defined: a RANGE write whose data[CH_W-1:0]==0 is acknowledged normally but does not change the register and produces no update_pulse. This lets the HPS update a subset of channels by writing zero to the rest.
- Undefined: zero is stored like any other value and update_pulse fires.

Test Plan:
- Reset, then read RANGE[0..3] (defaults) -> each returns 0x00000080; ID returns 0x52500408; waitrequest low exactly at cycle 2 of each read.
- Write 0x1234_56C3 to addr 2 -> range_out[23:16]=0xC3; update_pulse=0b0100 for exactly 1 cycle; other channels unchanged.
- Write 0 to addr 1 -> with ZERO_HOLD_EN: range_out[15:8] stays 0x80, no pulse; without: becomes 0x00, pulse on bit 1.
- Write IRQ_ENABLE=0x5, then pulse irq_src[0] and irq_src[1] -> IRQ_STATUS=0x3, irq=1. W1C with 0x1 -> status=0x2, irq=0.
- W1C of bit 0 in the same cycle as an irq_src[0] rising edge -> status bit 0 stays 1.
- Assert reset during WAIT of a write to addr 0 with WAIT_CYCLES=3 -> RANGE[0] remains 0x80, no pulse; the transfer completes after reset deasserts, 4 cycles after IDLE re-entry.
